btn_cmd_conditioner: RTL
========================

# btn_cmd_conditioner

Input-side companion to the counter/display path. Takes the three raw pad-level command inputs (count reset, start, stop) straight from `io_in` and produces clean, synchronized, debounced single-cycle command pulses for the counter core. It sits between the user-area pads and `counter_top`. It also drives the pad output-enable bits for its three input pads.

## Interface

Parameters:
- `DEB_W`, default 16: debounce counter width.
- `DEB_CNT`, default 50000: consecutive cycles a synchronized input must differ from its committed level before the change is accepted.
  - Legal range is 1 ≤ DEB_CNT ≤ 2^DEB_W − 1.

Ports:
- `clk` in 1: single clock domain; all state in the block is clocked by `clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `pad_rst_i` in 1: raw count-reset button, asynchronous to `clk`.
- `pad_start_i` in 1: raw start button, asynchronous.
- `pad_stop_i` in 1: raw stop button, asynchronous.
- `cnt_rst_o` out 1: one-cycle count-reset command pulse.
- `cnt_start_o` out 1: one-cycle start command pulse.
- `cnt_stop_o` out 1: one-cycle stop command pulse.
- `btn_level_o` out 3: committed debounced levels.
  - Bit mapping: [2] = rst, [1] = stop, [0] = start.
- `pad_oeb_o` out 3: output-enable bits for the three pads; constant 3'b111 (input mode).

## Operation

- Each channel has the same pipeline: raw pad → optional inversion → 2-flop synchronizer → debounce counter → committed level L → rising-edge pulse.
- Debounce rule, per channel. Let `s` be the synchronizer output and `c` the counter.
  - If s == L, then c ← 0.
  - Otherwise, if c == DEB_CNT−1, then L ← s and c ← 0. This is the "commit" event.
  - Otherwise c ← c+1.
- Any bounce back to L before commit clears `c`; the count restarts from zero on the next differing cycle.
- A raw pulse shorter than DEB_CNT synchronized cycles is therefore never committed.
- Pulse generation: a channel's candidate pulse is registered high in the cycle its commit moves L from 0 to 1. A commit from 1 to 0 produces no pulse.
- Arbitration when candidate pulses coincide in the same cycle:
  - Priority is rst > stop > start.
  - Only the winning pulse is driven. Losers are dropped, not deferred.
  - L still updates on every channel that commits.
- A button held high produces exactly one pulse. A second pulse requires release, a 1→0 commit, then a fresh 0→1 commit.
- `btn_level_o` reflects L directly and is registered.

## Timing

- Reset (`rst_n` low, asynchronous):
  - Synchronizer flops, L and `c` go to the released level. Released is 0 in the default build; see Configuration.
  - All pulse outputs go to 0.
  - `btn_level_o` = 3'b000.
  - `pad_oeb_o` = 3'b111 at all times, including during reset.
- Latency: let the raw input be first sampled asserted at edge 0 and held steady.
  - The synchronizer output is valid after edge 1.
  - The commit occurs at edge DEB_CNT+1.
  - The pulse is high for exactly the cycle between edges DEB_CNT+1 and DEB_CNT+2.
  - `btn_level_o` bit rises at edge DEB_CNT+1.
- Release latency is identical: L falls at edge DEB_CNT+1 after the release is first sampled.
- Reset asserted mid-count: `c` is cleared and any in-flight pulse is killed immediately. After deassertion, a held button must be re-qualified for the full DEB_CNT cycles before its pulse issues.
- Reset deassertion is synchronized externally; the block does not re-synchronize `rst_n`.
- Counter wrap: `c` never exceeds DEB_CNT−1, so no overflow is possible at any legal parameter value.

## Configuration

- Macro: `BTN_ACTIVE_LOW_EN`.
- Defined:
  - Raw pads are treated as active-low (pressed = 0).
  - Each raw input is inverted before the synchronizer.
  - Synchronizer flops reset to the inverted-domain released value. As a result, L, `btn_level_o` and pulse polarity are unchanged: 1 means pressed.
  - No spurious pulse is issued after reset when pads idle high.
- Undefined: pads are active-high and no inversion is applied.

## Test plan

Every scenario runs at DEB_CNT=4 unless it states otherwise.

- Clean press: `pad_start_i` 0→1 at edge 0, held for 20 cycles → `cnt_start_o` high only between edges 5 and 6; `btn_level_o` = 3'b001 from edge 5.
- Bounce: `pad_stop_i` toggled 1,1,0,1,1,1,1 in consecutive cycles → exactly one `cnt_stop_o` pulse, issued 4 cycles after the last 0 clears.
- Short glitch: `pad_rst_i` high for 3 cycles, then low → no `cnt_rst_o` pulse; `btn_level_o[2]` stays 0.
- Simultaneous: start and stop rise at the same edge and are held → only `cnt_stop_o` pulses; `btn_level_o` = 3'b011.
  - Repeat with all three pads rising together → only `cnt_rst_o` pulses.
- Reset mid-count: hold start; assert `rst_n` low at edge 3 for 2 cycles, then release → no pulse before reset; pulse issues DEB_CNT+1 edges after the first post-reset sample.
- Build with `BTN_ACTIVE_LOW_EN` and pads idling at 1 → no pulses after reset; driving `pad_start_i` to 0 and holding it yields one `cnt_start_o` pulse at edge 5.

Source files
------------

// File: rtl/btn_cmd_conditioner.sv
// Pad command conditioner: sync + debounce + rising-edge pulse for rst/stop/start.
// Define BTN_ACTIVE_LOW_EN for active-low pads (inverted before the synchronizer).
module btn_cmd_conditioner #(
    parameter int DEB_W   = 16,
    parameter int DEB_CNT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pad_rst_i,
    input  logic       pad_start_i,
    input  logic       pad_stop_i,
    output logic       cnt_rst_o,
    output logic       cnt_start_o,
    output logic       cnt_stop_o,
    output logic [2:0] btn_level_o,
    output logic [2:0] pad_oeb_o
);
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

    // Channel order everywhere: [2] = rst, [1] = stop, [0] = start.
    logic [2:0]            raw;
    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            lvl_q, lvl_d;
    logic [2:0]            pulse_q, pulse_d;
    logic [2:0]            rise;
    logic [2:0][DEB_W-1:0] cnt_q, cnt_d;

`ifdef BTN_ACTIVE_LOW_EN
    assign raw = ~{pad_rst_i, pad_stop_i, pad_start_i};
`else
    assign raw = {pad_rst_i, pad_stop_i, pad_start_i};
`endif

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        rise  = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i] = sync2_q[i];
                    rise[i]  = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Losing candidates are dropped, never queued.
    always_comb begin
        pulse_d = '0;
        if (rise[2])      pulse_d[2] = 1'b1;
        else if (rise[1]) pulse_d[1] = 1'b1;
        else if (rise[0]) pulse_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign cnt_rst_o   = pulse_q[2];
    assign cnt_stop_o  = pulse_q[1];
    assign cnt_start_o = pulse_q[0];
    assign btn_level_o = lvl_q;
    assign pad_oeb_o   = 3'b111;

endmodule
